// File: rtl/pcileech_sysctl_pkg.sv
// Shared state encodings, counter widths and a saturating increment for the sysctl sequencer.
// Pure declarations; no timing or backpressure involved.
package pcileech_sysctl_pkg;

    localparam int HOLD_W = 32;
    localparam int TICK_W = 64;

    typedef enum logic [1:0] {
        S_RESET,
        S_RUN,
        S_HELD,
        S_RELOADED
    } sysctl_state_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_ASSERT,
        W_HOLDOFF
    } wake_state_t;

    function automatic logic [HOLD_W-1:0] hold_inc(input logic [HOLD_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/pcileech_sysctl_debounce.sv
// Two-flop synchronizer plus stable-count debouncer for one active-low button.
// Latency: output follows a settled input after 2 + DEBOUNCE_CYCLES cycles; no backpressure.
module pcileech_sysctl_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw_n,
    output logic btn_db_n
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [1:0]       sync;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync     <= 2'b11;
            cnt      <= '0;
            btn_db_n <= 1'b1;
        end else begin
            sync <= {sync[0], btn_raw_n};
            // Any sample agreeing with the accepted level restarts the stability window.
            if (sync[1] == btn_db_n) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                btn_db_n <= sync[1];
                cnt      <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pcileech_sysctl.sv
// Board sequencer: button debounce, fabric soft reset, config reload, PCIe WAKE# and power LED.
// Latency: all outputs registered; rst_out releases RST_HOLD_CYCLES after reset sources clear; no backpressure.
module pcileech_sysctl
    import pcileech_sysctl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int RST_HOLD_CYCLES = 64,
    parameter int RELOAD_CYCLES   = 500000000,
    parameter int WAKE_CYCLES     = 100000,
    parameter int BLINK_BIT       = 24,
    parameter int BLINK_END_BIT   = 27
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sw_rst_n,
    input  logic              sw_aux_n,
    input  logic              pcie_perst_n,
    input  logic              wake_req,
    output logic              rst_out,
    output logic              cfg_reload,
    output logic              pcie_wake_n,
    output logic              led_pwronblink,
    output logic [TICK_W-1:0] tickcount
);

    logic              btn_rst_n;
    logic              aux_n;
    logic              btn_rst;
    logic [1:0]        perst_sync;
    logic              perst_s;
    sysctl_state_t     state;
    wake_state_t       wstate;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] wake_cnt;

    pcileech_sysctl_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_rst (
        .clk      (clk),
        .rst      (rst),
        .btn_raw_n(sw_rst_n),
        .btn_db_n (btn_rst_n)
    );

    pcileech_sysctl_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_aux (
        .clk      (clk),
        .rst      (rst),
        .btn_raw_n(sw_aux_n),
        .btn_db_n (aux_n)
    );

    assign btn_rst = ~btn_rst_n;
    assign perst_s = perst_sync[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_RESET;
            hold_cnt   <= '0;
            rst_out    <= 1'b1;
            cfg_reload <= 1'b0;
            tickcount  <= '0;
        end else begin
            cfg_reload <= 1'b0;
            rst_out    <= 1'b1;
            tickcount  <= (state == S_RUN) ? tickcount + 1'b1 : '0;
            unique case (state)
                S_RESET: begin
                    if (btn_rst) begin
                        state    <= S_HELD;
                        hold_cnt <= '0;
                    end else if (hold_cnt == HOLD_W'(RST_HOLD_CYCLES - 1)) begin
                        state    <= S_RUN;
                        hold_cnt <= '0;
                        rst_out  <= 1'b0;
                    end else begin
                        hold_cnt <= hold_inc(hold_cnt);
                    end
                end
                S_RUN: begin
                    if (btn_rst) begin
                        state    <= S_HELD;
                        hold_cnt <= '0;
                    end else begin
                        rst_out <= 1'b0;
                    end
                end
                S_HELD: begin
                    // An early release falls back to a normal reset-hold sequence.
                    if (!btn_rst) begin
                        state    <= S_RESET;
                        hold_cnt <= '0;
                    end else if (hold_cnt == HOLD_W'(RELOAD_CYCLES - 1)) begin
                        state      <= S_RELOADED;
                        cfg_reload <= 1'b1;
                        hold_cnt   <= '0;
                    end else begin
                        hold_cnt <= hold_inc(hold_cnt);
                    end
                end
                S_RELOADED: begin
                    if (!btn_rst) begin
                        state    <= S_RESET;
                        hold_cnt <= '0;
                    end
                end
                default: begin
                    state    <= S_RESET;
                    hold_cnt <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perst_sync  <= 2'b11;
            wstate      <= W_IDLE;
            wake_cnt    <= '0;
            pcie_wake_n <= 1'b1;
        end else begin
            perst_sync <= {perst_sync[0], pcie_perst_n};
            if (state != S_RUN) begin
                wstate      <= W_IDLE;
                wake_cnt    <= '0;
                pcie_wake_n <= 1'b1;
            end else begin
                unique case (wstate)
                    W_IDLE: begin
                        if (wake_req && perst_s) begin
                            wstate      <= W_ASSERT;
                            wake_cnt    <= '0;
                            pcie_wake_n <= 1'b0;
                        end
                    end
                    W_ASSERT: begin
                        if (!perst_s || wake_cnt == HOLD_W'(WAKE_CYCLES - 1)) begin
                            wstate      <= W_HOLDOFF;
                            wake_cnt    <= '0;
                            pcie_wake_n <= 1'b1;
                        end else begin
                            wake_cnt <= hold_inc(wake_cnt);
                        end
                    end
                    W_HOLDOFF: begin
                        if (wake_cnt == HOLD_W'(WAKE_CYCLES - 1)) begin
                            wstate   <= W_IDLE;
                            wake_cnt <= '0;
                        end else begin
                            wake_cnt <= hold_inc(wake_cnt);
                        end
                    end
                    default: begin
                        wstate      <= W_IDLE;
                        wake_cnt    <= '0;
                        pcie_wake_n <= 1'b1;
                    end
                endcase
            end
        end
    end

    // Blink runs only during the first 2^BLINK_END_BIT ticks after release.
    always_ff @(posedge clk) begin
        if (rst) begin
            led_pwronblink <= 1'b0;
        end else begin
            led_pwronblink <= ~aux_n ^ (tickcount[BLINK_BIT] &
                                        ((tickcount >> BLINK_END_BIT) == '0));
        end
    end

endmodule

// File: tb/tb_pcileech_sysctl.sv
// Self-checking bench for pcileech_sysctl with shortened timing parameters.
module tb_pcileech_sysctl;

    localparam int DB = 4;
    localparam int RH = 8;
    localparam int RL = 100;
    localparam int WK = 5;
    localparam int BB = 2;
    localparam int BE = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        sw_rst_n;
    logic        sw_aux_n;
    logic        pcie_perst_n;
    logic        wake_req;
    logic        rst_out;
    logic        cfg_reload;
    logic        pcie_wake_n;
    logic        led_pwronblink;
    logic [63:0] tickcount;

    typedef struct {
        int   tick;
        logic exp_led;
    } led_vec_t;

    led_vec_t    vec[24];
    logic        exp_q[$];
    logic        e_led;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          n;
    int          rl_hits, rise_at, rel_first, rel_cnt, hi_drop, lo, lows;
    logic [63:0] exp_t;

    pcileech_sysctl #(
        .DEBOUNCE_CYCLES(DB),
        .RST_HOLD_CYCLES(RH),
        .RELOAD_CYCLES  (RL),
        .WAKE_CYCLES    (WK),
        .BLINK_BIT      (BB),
        .BLINK_END_BIT  (BE)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .sw_rst_n      (sw_rst_n),
        .sw_aux_n      (sw_aux_n),
        .pcie_perst_n  (pcie_perst_n),
        .wake_req      (wake_req),
        .rst_out       (rst_out),
        .cfg_reload    (cfg_reload),
        .pcie_wake_n   (pcie_wake_n),
        .led_pwronblink(led_pwronblink),
        .tickcount     (tickcount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo_v, input int hi_v);
        n_cmp++;
        if (act < lo_v || act > hi_v) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo_v, hi_v);
        end
    endtask

    task automatic cyc(input int k);
        repeat (k) @(negedge clk);
    endtask

    // Advances negedge by negedge until rst_out equals val, giving up after limit cycles.
    task automatic wait_rst_out(input logic val, input int limit, output int cnt);
        cnt = 0;
        while (rst_out !== val && cnt < limit) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst          = 1'b1;
        sw_rst_n     = 1'b1;
        sw_aux_n     = 1'b1;
        pcie_perst_n = 1'b1;
        wake_req     = 1'b0;
        for (int i = 0; i < 24; i++) begin
            vec[i].tick    = i;
            vec[i].exp_led = (((i >> BB) & 1) == 1) && (i < (1 << BE));
        end

        // Power-on
        cyc(3);
        chk("reset_rst_out", rst_out, 1);
        chk("reset_cfg_reload", cfg_reload, 0);
        chk("reset_wake_n", pcie_wake_n, 1);
        chk("reset_tick", tickcount, 0);
        chk("reset_led", led_pwronblink, 0);
        rst = 1'b0;
        for (int k = 1; k <= RH; k++) begin
            cyc(1);
            chk("por_rst_out", rst_out, (k < RH));
        end
        chk("por_tick0", tickcount, 0);
        cyc(10);
        chk("por_tick10", tickcount, 10);
        exp_t = 10;

        // Bounce: 3-cycle glitches never survive the debounce window
        for (int r = 0; r < 5; r++) begin
            for (int ph = 0; ph < 2; ph++) begin
                sw_rst_n = (ph == 1);
                repeat (3) begin
                    cyc(1);
                    exp_t++;
                    chk("bounce_rst_out", rst_out, 0);
                    chk("bounce_tick", tickcount, exp_t);
                end
            end
        end

        // Short press: btn_rst lands 2+DB cycles after press, rst_out registers behind it
        sw_rst_n = 1'b0;
        cyc(5);
        chk("press_rst_out_early", rst_out, 0);
        cyc(2);
        chk("press_rst_out_up", rst_out, 1);
        rl_hits = 0;
        for (int k = 7; k < 50; k++) begin
            cyc(1);
            if (cfg_reload !== 1'b0 || rst_out !== 1'b1) rl_hits++;
        end
        chk("short_no_reload", rl_hits, 0);
        sw_rst_n = 1'b1;
        wait_rst_out(1'b0, 40, n);
        chk_rng("short_release_to_fall", n, 2 + DB + RH, 3 + DB + RH);
        chk("short_tick_restart", tickcount, 0);
        cyc(1);
        chk("short_tick_1", tickcount, 1);

        // Long press
        sw_rst_n  = 1'b0;
        rise_at   = -1;
        rel_first = -1;
        rel_cnt   = 0;
        hi_drop   = 0;
        for (int k = 1; k <= 300; k++) begin
            cyc(1);
            if (rst_out === 1'b1 && rise_at < 0) rise_at = k;
            if (rise_at >= 0 && rst_out !== 1'b1) hi_drop++;
            if (cfg_reload === 1'b1) begin
                rel_cnt++;
                if (rel_first < 0) rel_first = k;
            end
        end
        chk_rng("long_rise", rise_at, 2 + DB, 3 + DB);
        chk("long_reload_count", rel_cnt, 1);
        chk("long_reload_delay", rel_first - rise_at, RL);
        chk("long_rst_out_held", hi_drop, 0);
        sw_rst_n = 1'b1;
        wait_rst_out(1'b0, 40, n);
        chk_rng("long_release_to_fall", n, 2 + DB + RH, 3 + DB + RH);

        // Wake pulse, holdoff and PERST# abort
        cyc(2);
        wake_req = 1'b1;
        cyc(1);
        wake_req = 1'b0;
        chk("wake_assert", pcie_wake_n, 0);
        lo = 1;
        while (lo < 20) begin
            cyc(1);
            if (pcie_wake_n !== 1'b0) break;
            lo++;
        end
        chk("wake_width", lo, WK);
        cyc(1);
        wake_req = 1'b1;
        cyc(1);
        wake_req = 1'b0;
        lows = 0;
        repeat (3) begin
            cyc(1);
            if (pcie_wake_n !== 1'b1) lows++;
        end
        chk("wake_ignored", lows, 0);
        wake_req = 1'b1;
        cyc(1);
        wake_req = 1'b0;
        chk("wake_second", pcie_wake_n, 0);
        pcie_perst_n = 1'b0;
        cyc(2);
        chk("wake_abort_pending", pcie_wake_n, 0);
        cyc(1);
        chk("wake_abort", pcie_wake_n, 1);
        pcie_perst_n = 1'b1;
        cyc(12);

        // Blink table from a fresh power-on
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        wait_rst_out(1'b0, 20, n);
        chk("blink_por_fall", n, RH);
        for (int j = 0; j < 24; j++) begin
            if (exp_q.size() > 0) begin
                e_led = exp_q.pop_front();
                chk("blink_led", led_pwronblink, e_led);
            end
            chk("blink_tick", tickcount, vec[j].tick);
            exp_q.push_back(vec[j].exp_led);
            cyc(1);
        end
        e_led = exp_q.pop_front();
        chk("blink_led_last", led_pwronblink, e_led);

        // Aux button inverts the LED
        sw_aux_n = 1'b0;
        cyc(8);
        chk("aux_inv_on", led_pwronblink, 1);
        sw_aux_n = 1'b1;
        cyc(8);
        chk("aux_inv_off", led_pwronblink, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
